pixel_row_assembler: RTL and testbench

Upstream feeder for `subpixel_interpolation`. It accepts a serial 8-bit pixel stream with a valid/ready handshake and packs every 15 consecutive pixels into one 120-bit `in_row` word. Completed rows go into a small register FIFO, which presents the head row to the interpolator together with its row index. This replaces the memory-array row source used in simulation and lets the interpolation stage run from a real pixel interface.

---
 rtl/subpel_pkg.sv | 9 +
 rtl/row_fifo.sv | 66 ++++++
 rtl/pixel_row_assembler.sv | 93 +++++++++
 tb/tb_pixel_row_assembler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/subpel_pkg.sv
// Shared pixel/row definitions for the row assembler and the interpolator.
package subpel_pkg;
  localparam int PIX_W      = 8;
  localparam int ROW_PIX    = 15;
  localparam int ROW_W      = PIX_W * ROW_PIX;
  localparam int FIFO_DEPTH = 4;

  typedef logic [ROW_W-1:0] row_t;
endpackage

// File: rtl/row_fifo.sv
// DEPTH x W register FIFO with combinational head read; head reads 0 when empty.
module row_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 120,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   fill_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          do_push, do_pop;

  assign full_o  = (fill_q == (AW+1)'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   fill_d = fill_q + (AW+1)'(1);
      2'b01:   fill_d = fill_q - (AW+1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Row storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; fill gating on data_o hides stale contents.
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_row_assembler.sv
// Packs a serial pixel stream into ROW_PIX-pixel row words and queues them for the interpolator.
module pixel_row_assembler
  import subpel_pkg::*;
#(
  parameter  int PIX_W   = subpel_pkg::PIX_W,
  parameter  int ROW_PIX = subpel_pkg::ROW_PIX,
  parameter  int DEPTH   = subpel_pkg::FIFO_DEPTH,
  localparam int ROW_W   = PIX_W * ROW_PIX,
  localparam int AW      = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(ROW_PIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             sof,
  output logic [ROW_W-1:0] in_row,
  output logic             row_valid,
  input  logic             row_pop,
  output logic [15:0]      row_idx,
  output logic [AW:0]      fill,
  output logic             drop_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_PIX - 1);

  logic [ROW_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             drop_err_q, drop_err_d;
  logic [15:0]      row_idx_q;
  logic             accept, push, full, empty, do_pop;

  // Only the final byte of a row waits on a full FIFO; no path from row_pop.
  assign pix_ready = !((byte_cnt_q == LAST) && full);
  assign accept    = pix_valid && pix_ready;
  assign row_valid = !empty;
  assign do_pop    = row_pop && row_valid;
  assign row_idx   = row_idx_q;
  assign drop_err  = drop_err_q;

  // Shift register, byte counter and start-of-frame handling.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    drop_err_d = drop_err_q;
    push       = 1'b0;
    if (accept) begin
      shift_d = {shift_q[ROW_W-PIX_W-1:0], pix_in};
      if (sof && (byte_cnt_q != '0)) begin
        // Older bytes age out of the shift register before the next push.
        drop_err_d = 1'b1;
        byte_cnt_d = CNT_W'(1);
      end else if (byte_cnt_q == LAST) begin
        push       = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + CNT_W'(1);
      end
    end
  end

  // Assembly state and head-row index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
      drop_err_q <= 1'b0;
      row_idx_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      drop_err_q <= drop_err_d;
      if (do_pop) row_idx_q <= row_idx_q + 16'd1;
    end
  end

  row_fifo #(
    .DEPTH (DEPTH),
    .W     (ROW_W)
  ) u_row_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (row_pop),
    .data_i  (shift_d),
    .data_o  (in_row),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

endmodule

// File: tb/tb_pixel_row_assembler.sv
// Scoreboard bench for pixel_row_assembler: stimulus queues expected rows, a monitor checks pops.
module tb_pixel_row_assembler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   pix_in = '0;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic         sof = 1'b0;
  logic [119:0] in_row;
  logic         row_valid;
  logic         row_pop = 1'b0;
  logic [15:0]  row_idx;
  logic [2:0]   fill;
  logic         drop_err;

  int errors = 0;
  int checks = 0;
  logic [119:0] exp_q[$];
  int unsigned  pop_cnt = 0;

  always #5 clk = ~clk;

  pixel_row_assembler dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .sof       (sof),
    .in_row    (in_row),
    .row_valid (row_valid),
    .row_pop   (row_pop),
    .row_idx   (row_idx),
    .fill      (fill),
    .drop_err  (drop_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] row_of(input logic [7:0] base);
    logic [119:0] r;
    for (int i = 0; i < 15; i++) r[119-8*i -: 8] = 8'(base + i);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input logic s);
    int n;
    n = 0;
    pix_in = b; sof = s; pix_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      n++;
      if (n > 20) begin
        errors++; checks++;
        $display("FAIL accept_timeout: byte %0h never accepted", b);
        break;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(base + i), 1'b0);
  endtask

  task automatic send_row(input logic [7:0] base);
    exp_q.push_back(row_of(base));
    send_bytes(base, 15);
  endtask

  task automatic pop_row();
    row_pop = 1'b1;
    @(posedge clk); #1;
    row_pop = 1'b0;
  endtask

  // Monitor: every effective pop must match the oldest expected row and index.
  initial forever begin
    @(negedge clk);
    if (rst) pop_cnt = 0;
    else if (row_pop && row_valid) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_row: got %0h with no expected row", in_row);
      end else begin
        check("row_data", in_row, exp_q.pop_front());
        check("row_idx", row_idx, 128'(pop_cnt[15:0]));
        pop_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", pix_ready, 1);
    check("rst_valid", row_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_in_row", in_row, 0);
    check("rst_idx", row_idx, 0);
    check("rst_drop", drop_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single row.
    send_row(8'h00);
    check("t1_valid", row_valid, 1);
    check("t1_row", in_row, 120'h000102030405060708090A0B0C0D0E);
    check("t1_fill", fill, 1);
    check("t1_idx", row_idx, 0);

    // Full stall on the final byte.
    send_row(8'h10);
    send_row(8'h20);
    send_row(8'h30);
    check("t2_fill4", fill, 4);
    send_bytes(8'h40, 14);
    exp_q.push_back(row_of(8'h40));
    pix_in = 8'h4E; pix_valid = 1'b1;
    @(negedge clk);
    check("t2_stall", pix_ready, 0);
    @(posedge clk); #1;
    check("t2_fill_hold", fill, 4);
    pop_row();
    check("t2_ready_back", pix_ready, 1);
    check("t2_fill3", fill, 3);
    check("t2_idx1", row_idx, 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check("t2_fill_refill", fill, 4);
    pop_row();
    pop_row();
    check("t3_fill2", fill, 2);

    // Push and pop on the same edge.
    send_bytes(8'h50, 14);
    exp_q.push_back(row_of(8'h50));
    pix_in = 8'h5E; pix_valid = 1'b1; row_pop = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0; row_pop = 1'b0;
    check("t3_fill_same", fill, 2);
    pop_row();
    pop_row();
    check("t3_empty", row_valid, 0);
    check("t3_in_row0", in_row, 0);
    check("t3_idx6", row_idx, 6);

    // sof mid-row discards the partial row.
    send_bytes(8'h60, 7);
    send_byte(8'hAA, 1'b1);
    check("t4_drop", drop_err, 1);
    check("t4_no_row", fill, 0);
    exp_q.push_back(row_of(8'hAA));
    send_bytes(8'hAB, 14);
    check("t4_fill1", fill, 1);
    check("t4_row", in_row, row_of(8'hAA));
    check("t4_drop_sticky", drop_err, 1);
    pop_row();
    // sof on byte 0 is a normal start.
    exp_q.push_back(row_of(8'hC0));
    send_byte(8'hC0, 1'b1);
    send_bytes(8'hC1, 14);
    check("t4_sof0_fill", fill, 1);
    pop_row();

    // Asynchronous reset mid-row with a non-empty FIFO.
    send_row(8'h00);
    send_row(8'h10);
    send_row(8'h20);
    send_bytes(8'h70, 9);
    check("t5_fill3", fill, 3);
    #2 rst = 1'b1;
    #1;
    check("t5_valid", row_valid, 0);
    check("t5_fill", fill, 0);
    check("t5_in_row", in_row, 0);
    check("t5_ready", pix_ready, 1);
    check("t5_drop", drop_err, 0);
    check("t5_idx", row_idx, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_ready_after", pix_ready, 1);
    send_row(8'hD0);
    check("t5_fresh_fill", fill, 1);
    check("t5_fresh_row", in_row, row_of(8'hD0));
    pop_row();
    check("queue_drained", 128'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
